regdst_wport_arbiter: RTL and testbench

- Sequential arbiter for the register-file write port. It shares the 5-bit destination mux and the write port between two write-back requesters: A (ALU result path) and B (load / long-latency unit path).
- It drives the mux select, the registered write enable, the write address and the write data.
- Arbitration is round-robin, with an optional bounded lock for back-to-back bursts.

---
 rtl/regdst_wport_arbiter.sv | 165 ++++++++++++++++
 tb/tb_regdst_wport_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regdst_wport_arbiter.sv
// Register-file write-port arbiter: round-robin between the ALU path (A) and the
// load path (B), with a bounded ownership lock for back-to-back bursts.
module regdst_wport_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int MAX_LOCK   = 4,
  parameter int RESET_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          lock_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          req_b,
  input  logic          lock_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          sel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          drop_zero,
  output logic [1:0]    dbg_state,
  output logic          dbg_ptr,
  output logic [3:0]    dbg_lock_cnt
);

  // Handshake: a requester holds req/lock/addr/data stable until it sees its
  // gnt in the same cycle; the request is accepted on the edge ending that cycle.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_e;

  localparam logic       RST_PTR = (RESET_PRIO != 0);
  localparam logic [4:0] MAX_L   = 5'(MAX_LOCK);
  // A limit of one grant means a lock can never extend ownership.
  localparam logic       LOCK_EN = (MAX_LOCK > 1);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [3:0]    lock_cnt_q, lock_cnt_d;
  logic          sel_q, sel_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          drop_q, drop_d;

  logic          gnt_a_c, gnt_b_c;
  logic          granted, win, win_lock;
  logic [AW-1:0] win_addr;
  logic [4:0]    cnt_inc;

  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_a && (!req_b || !ptr_q)) gnt_a_c = 1'b1;
        else if (req_b)                  gnt_b_c = 1'b1;
      end
      ST_OWN_A: gnt_a_c = req_a;
      ST_OWN_B: gnt_b_c = req_b;
      default: ;
    endcase
  end

  assign granted  = gnt_a_c | gnt_b_c;
  assign win      = gnt_b_c;
  assign win_lock = win ? lock_b : lock_a;
  assign win_addr = win ? addr_b : addr_a;
  assign cnt_inc  = {1'b0, lock_cnt_q} + 5'd1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (granted) begin
          ptr_d = ~win;
          if (win_lock && LOCK_EN) begin
            state_d    = win ? ST_OWN_B : ST_OWN_A;
            lock_cnt_d = 4'd1;
          end
        end
      end
      ST_OWN_A, ST_OWN_B: begin
        if (!granted) begin
          state_d    = ST_IDLE;
          lock_cnt_d = 4'd0;
        end else if (cnt_inc >= MAX_L) begin
          // Burst limit reached: hand priority to the side that was kept waiting.
          state_d    = ST_IDLE;
          lock_cnt_d = 4'd0;
          ptr_d      = ~win;
        end else if (win_lock) begin
          lock_cnt_d = cnt_inc[3:0];
        end else begin
          state_d    = ST_IDLE;
          lock_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    sel_d     = sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    drop_d    = 1'b0;
    if (granted) begin
      sel_d     = win;
      wr_addr_d = win_addr;
      wr_data_d = win ? data_b : data_a;
      // Register 0 is hardwired: the accepted write is discarded and flagged.
      wr_en_d   = (win_addr != '0);
      drop_d    = (win_addr == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= RST_PTR;
      lock_cnt_q <= 4'd0;
      sel_q      <= RST_PTR;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      sel_q      <= sel_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      drop_q     <= drop_d;
    end
  end

  assign gnt_a        = gnt_a_c;
  assign gnt_b        = gnt_b_c;
  assign sel          = sel_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign drop_zero    = drop_q;
  assign dbg_state    = state_q;
  assign dbg_ptr      = ptr_q;
  assign dbg_lock_cnt = lock_cnt_q;

endmodule

// File: tb/tb_regdst_wport_arbiter.sv
// Bench for regdst_wport_arbiter: directed scenarios plus random traffic checked
// against an ownership/streak model of the arbitration rules.
module tb_regdst_wport_arbiter;

  localparam int AW         = 5;
  localparam int DW         = 32;
  localparam int MAX_LOCK   = 4;
  localparam int RESET_PRIO = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_a = 1'b0, lock_a = 1'b0, req_b = 1'b0, lock_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          gnt_a, gnt_b, sel, wr_en, drop_zero, dbg_ptr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_lock_cnt;

  regdst_wport_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK), .RESET_PRIO(RESET_PRIO)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .lock_a(lock_a), .addr_a(addr_a), .data_a(data_a),
    .req_b(req_b), .lock_b(lock_b), .addr_b(addr_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .drop_zero(drop_zero),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr), .dbg_lock_cnt(dbg_lock_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW:0] exp_q[$];

  int m_ptr;      // side favoured on contention
  int m_owner;    // -1 none, 0 A, 1 B
  int m_streak;   // consecutive grants held under the current lock
  int m_last_g;   // model grant of the last step
  int obs_g;      // DUT grant of the last step
  logic          e_sel, e_wr_en, e_drop;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = RESET_PRIO;
    m_owner  = -1;
    m_streak = 0;
    e_sel    = (RESET_PRIO != 0);
    e_wr_en  = 1'b0;
    e_drop   = 1'b0;
    e_addr   = '0;
    e_data   = '0;
    exp_q.delete();
  endtask

  function automatic int model_grant(input logic ra, input logic rb);
    if (m_owner == 0) return ra ? 0 : -1;
    if (m_owner == 1) return rb ? 1 : -1;
    if (ra && rb) return m_ptr;
    if (ra) return 0;
    if (rb) return 1;
    return -1;
  endfunction

  task automatic model_update(input int g, input logic lk);
    if (m_owner < 0) begin
      if (g >= 0) begin
        m_ptr = 1 - g;
        if (lk && MAX_LOCK > 1) begin
          m_owner  = g;
          m_streak = 1;
        end
      end
    end else if (g < 0) begin
      m_owner  = -1;
      m_streak = 0;
    end else begin
      m_streak++;
      if (m_streak >= MAX_LOCK) begin
        m_owner  = -1;
        m_streak = 0;
        m_ptr    = 1 - g;
      end else if (!lk) begin
        m_owner  = -1;
        m_streak = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left one time unit after a rising edge.
  task automatic step(input logic ra, input logic la, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic rb, input logic lb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    int g;
    logic [AW+DW:0] pkt;
    req_a = ra; lock_a = la; addr_a = aa; data_a = da;
    req_b = rb; lock_b = lb; addr_b = ab; data_b = db;
    #3;
    g = model_grant(ra, rb);
    m_last_g = g;
    chk("gnt_a", gnt_a, (g == 0));
    chk("gnt_b", gnt_b, (g == 1));
    obs_g = (gnt_a === 1'b1) ? 0 : ((gnt_b === 1'b1) ? 1 : -1);
    if (g >= 0) begin
      e_sel   = (g == 1);
      e_addr  = (g == 1) ? ab : aa;
      e_data  = (g == 1) ? db : da;
      e_wr_en = (e_addr != '0);
      e_drop  = (e_addr == '0);
      if (e_wr_en) exp_q.push_back({e_sel, e_addr, e_data});
    end else begin
      e_wr_en = 1'b0;
      e_drop  = 1'b0;
    end
    model_update(g, (g == 1) ? lb : la);
    @(posedge clk);
    #1;
    chk("sel", sel, e_sel);
    chk("wr_en", wr_en, e_wr_en);
    chk("wr_addr", wr_addr, e_addr);
    chk("wr_data", wr_data, e_data);
    chk("drop_zero", drop_zero, e_drop);
    chk("lock_cnt", dbg_lock_cnt, m_streak);
    if (wr_en === 1'b1) begin
      chk("write_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        pkt = exp_q.pop_front();
        chk("write_pkt", {sel, wr_addr, wr_data}, pkt);
      end
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Asserts reset mid-cycle and checks the outputs clear before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_sel", sel, (RESET_PRIO != 0));
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_drop", drop_zero, 1'b0);
    chk("rst_state", dbg_state, 0);
    chk("rst_lock_cnt", dbg_lock_cnt, 0);
    req_a = 1'b0; lock_a = 1'b0; req_b = 1'b0; lock_b = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  int grants[8];
  logic          ca, cla, cb, clb;
  logic [AW-1:0] caa, cab;
  logic [DW-1:0] cda, cdb;
  logic          pend_a, pend_b;

  initial begin
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset pulse then single request from A
    do_reset();
    step(1'b1, 1'b0, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
    chk("single_gnt_a", obs_g, 0);
    chk("single_wr_en", wr_en, 1'b1);
    chk("single_wr_addr", wr_addr, 9);
    chk("single_wr_data", wr_data, 32'hDEAD_BEEF);
    chk("single_sel", sel, 1'b0);
    idle_step();
    chk("idle_hold_addr", wr_addr, 9);

    // Round robin between A (reg 3) and B (reg 7)
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 5'd3, 32'h0000_0A0A + k, 1'b1, 1'b0, 5'd7, 32'h0000_0B0B + k);
      chk("rr_sel", sel, k[0]);
      chk("rr_addr", wr_addr, (k % 2 == 0) ? 3 : 7);
    end

    // Lock held by A hits the burst limit
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 5'd4, 32'h100 + k, 1'b1, 1'b0, 5'd8, 32'h200 + k);
      grants[k] = obs_g;
      if (k == 4) chk("lock_timeout_sel", sel, 1'b1);
    end
    chk("lock_g0", grants[0], 0);
    chk("lock_g1", grants[1], 0);
    chk("lock_g2", grants[2], 0);
    chk("lock_g3", grants[3], 0);
    chk("lock_g4", grants[4], 1);

    // Early lock release on the third grant
    do_reset();
    step(1'b1, 1'b1, 5'd2, 32'h11, 1'b1, 1'b0, 5'd6, 32'h66);
    step(1'b1, 1'b1, 5'd2, 32'h12, 1'b1, 1'b0, 5'd6, 32'h66);
    chk("early_cnt2", dbg_lock_cnt, 2);
    step(1'b1, 1'b0, 5'd2, 32'h13, 1'b1, 1'b0, 5'd6, 32'h66);
    chk("early_g2", obs_g, 0);
    chk("early_cnt0", dbg_lock_cnt, 0);
    step(1'b1, 1'b0, 5'd2, 32'h14, 1'b1, 1'b0, 5'd6, 32'h66);
    chk("early_then_b", obs_g, 1);

    // Write to register 0 is discarded
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 32'h1234);
    chk("r0_gnt_b", obs_g, 1);
    chk("r0_wr_en", wr_en, 1'b0);
    chk("r0_drop", drop_zero, 1'b1);
    chk("r0_data", wr_data, 32'h1234);
    idle_step();
    chk("r0_drop_clear", drop_zero, 1'b0);

    // Reset while B owns the port with two grants taken
    do_reset();
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 5'd5, 32'h55);
    step(1'b1, 1'b0, 5'd6, 32'h66, 1'b1, 1'b1, 5'd5, 32'h56);
    chk("midlock_state", dbg_state, 2);
    chk("midlock_cnt", dbg_lock_cnt, 2);
    do_reset();
    step(1'b1, 1'b0, 5'd6, 32'h66, 1'b1, 1'b0, 5'd5, 32'h57);
    chk("post_reset_gnt_a", obs_g, 0);

    // Random traffic; requesters hold their request until granted
    pend_a = 1'b0; pend_b = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pend_a) begin
        ca  = ($urandom_range(0, 3) != 0);
        cla = $urandom_range(0, 1) == 1;
        caa = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
        cda = $urandom;
      end
      if (!pend_b) begin
        cb  = ($urandom_range(0, 2) != 0);
        clb = $urandom_range(0, 1) == 1;
        cab = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
        cdb = $urandom;
      end
      step(ca, cla, caa, cda, cb, clb, cab, cdb);
      pend_a = ca && (m_last_g != 0);
      pend_b = cb && (m_last_g != 1);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        pend_a = 1'b0; pend_b = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
